// File: rtl/dma_pcie_c2h_axis_gen.sv
// C2H AXI-Stream packet generator: turns a (qid, len, seed) command into a
// 512-bit beat stream with a counting 16-bit word pattern, byte parity and tail keep.
module dma_pcie_c2h_axis_gen #(
    parameter int TUSER_W = 32,
    parameter int LEN_W   = 16
) (
    input  logic               axi_aclk,
    input  logic               axi_aresetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [10:0]        cmd_qid,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [15:0]        cmd_seed,
    output logic [511:0]       tdata,
    output logic [63:0]        tparity,
    output logic [63:0]        tkeep,
    output logic               tlast,
    output logic               tvalid,
    input  logic               tready,
    output logic [TUSER_W-1:0] tusr,
    output logic               pkt_done,
    output logic               err_len0,
    output logic [31:0]        pkt_cnt
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high (after first post-reset edge)
    // SEND  | presenting beats until the tlast handshake
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state;
    logic [9:0]  beat;
    logic [9:0]  last_idx;
    logic [15:0] seed_r;
    logic [63:0] keep_last;

    logic [9:0]   cmd_last_idx;
    logic [63:0]  cmd_keep_last;
    logic [9:0]   nxt_beat;
    logic [15:0]  src_seed;
    logic [9:0]   src_beat;
    logic [511:0] nxt_data;
    logic [63:0]  nxt_par;
    logic         hs;

    function automatic logic [511:0] beat_data(input logic [15:0] seed, input logic [9:0] b);
        logic [15:0]  base;
        logic [511:0] d;
        base = seed + {1'b0, b, 5'b0};
        d    = '0;
        for (int k = 0; k < 32; k++) begin
            d[16*k +: 16] = base + 16'(k);
        end
        return d;
    endfunction

    function automatic logic [63:0] byte_parity(input logic [511:0] d);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 64; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

    function automatic logic [63:0] tail_keep(input logic [5:0] r);
        if (r == 6'd0) begin
            return '1;
        end
        return (64'd1 << r) - 64'd1;
    endfunction

    // The next beat is computed once and shared by command accept (beat 0 from
    // the live seed) and by a non-last handshake (beat+1 from the latched seed).
    always_comb begin
        cmd_last_idx  = 10'((cmd_len - LEN_W'(1)) >> 6);
        cmd_keep_last = tail_keep(cmd_len[5:0]);
        nxt_beat      = beat + 10'd1;
        hs            = tvalid && tready;
        if (state == IDLE) begin
            src_seed = cmd_seed;
            src_beat = '0;
        end else begin
            src_seed = seed_r;
            src_beat = nxt_beat;
        end
        nxt_data = beat_data(src_seed, src_beat);
        nxt_par  = byte_parity(nxt_data);
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            beat      <= '0;
            last_idx  <= '0;
            seed_r    <= '0;
            keep_last <= '0;
            tdata     <= '0;
            tparity   <= '0;
            tkeep     <= '0;
            tlast     <= 1'b0;
            tvalid    <= 1'b0;
            tusr      <= '0;
            pkt_done  <= 1'b0;
            err_len0  <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            pkt_done <= 1'b0;
            err_len0 <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_ready && cmd_valid) begin
                        if (cmd_len == '0) begin
                            err_len0 <= 1'b1;
                        end else begin
                            state     <= SEND;
                            cmd_ready <= 1'b0;
                            beat      <= '0;
                            last_idx  <= cmd_last_idx;
                            seed_r    <= cmd_seed;
                            keep_last <= cmd_keep_last;
                            tvalid    <= 1'b1;
                            tdata     <= nxt_data;
                            tparity   <= nxt_par;
                            tlast     <= (cmd_last_idx == 10'd0);
                            tkeep     <= (cmd_last_idx == 10'd0) ? cmd_keep_last : '1;
                            tusr      <= TUSER_W'({5'b0, cmd_len, cmd_qid});
                        end
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (tlast) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            tvalid    <= 1'b0;
                            tlast     <= 1'b0;
                            beat      <= '0;
                            pkt_done  <= 1'b1;
                            pkt_cnt   <= pkt_cnt + 32'd1;
                        end else begin
                            beat    <= nxt_beat;
                            tdata   <= nxt_data;
                            tparity <= nxt_par;
                            tlast   <= (nxt_beat == last_idx);
                            tkeep   <= (nxt_beat == last_idx) ? keep_last : '1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_pcie_c2h_axis_gen.sv
// Scoreboard bench for dma_pcie_c2h_axis_gen: stimulus queues expected beats,
// a negedge monitor compares every presented beat and the completion outputs.
module tb_dma_pcie_c2h_axis_gen;

    logic         axi_aclk = 1'b0;
    logic         axi_aresetn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [10:0]  cmd_qid;
    logic [15:0]  cmd_len;
    logic [15:0]  cmd_seed;
    logic [511:0] tdata;
    logic [63:0]  tparity;
    logic [63:0]  tkeep;
    logic         tlast;
    logic         tvalid;
    logic         tready;
    logic [31:0]  tusr;
    logic         pkt_done;
    logic         err_len0;
    logic [31:0]  pkt_cnt;

    dma_pcie_c2h_axis_gen #(.TUSER_W(32), .LEN_W(16)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_qid(cmd_qid),
        .cmd_len(cmd_len), .cmd_seed(cmd_seed),
        .tdata(tdata), .tparity(tparity), .tkeep(tkeep), .tlast(tlast),
        .tvalid(tvalid), .tready(tready), .tusr(tusr),
        .pkt_done(pkt_done), .err_len0(err_len0), .pkt_cnt(pkt_cnt)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        logic [31:0]  u;
    } beat_t;

    beat_t       q[$];
    int          total = 0;
    int          bad = 0;
    int          pops = 0;
    int          gap = -1;
    bit          chk_gap = 0;
    bit          exp_done = 0;
    logic [31:0] exp_cnt = 0;
    int          tr_mode = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] m_data(input int seed, input int b);
        logic [511:0] d;
        int w;
        d = '0;
        for (int k = 0; k < 32; k++) begin
            w = (seed + 32 * b + k) % 65536;
            d[16*k +: 16] = 16'(w);
        end
        return d;
    endfunction

    function automatic logic [63:0] m_par(input logic [511:0] d);
        logic [63:0] p;
        logic [7:0]  by;
        p = '0;
        for (int i = 0; i < 64; i++) begin
            by = d[8*i +: 8];
            p[i] = by[0] ^ by[1] ^ by[2] ^ by[3] ^ by[4] ^ by[5] ^ by[6] ^ by[7];
        end
        return p;
    endfunction

    function automatic logic [63:0] m_keep(input int len);
        logic [63:0] k;
        int r;
        r = len % 64;
        for (int i = 0; i < 64; i++) k[i] = (r == 0) || (i < r);
        return k;
    endfunction

    // Queue the expected beats, then hold the command until the DUT takes it.
    task automatic issue(input int qid, input int len, input int seed);
        int    n;
        beat_t e;
        bit    ok;
        n = (len + 63) / 64;
        for (int b = 0; b < n; b++) begin
            e.d = m_data(seed, b);
            e.l = (b == n - 1);
            e.k = e.l ? m_keep(len) : '1;
            e.u = {5'b0, 16'(len), 11'(qid)};
            q.push_back(e);
        end
        cmd_qid   = 11'(qid);
        cmd_len   = 16'(len);
        cmd_seed  = 16'(seed);
        cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge axi_aclk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL cmd_accept_timeout: got no cmd_ready want accept");
        end
        @(posedge axi_aclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input logic [31:0] want_cnt, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (q.size() == 0 && !tvalid) begin
                ok = 1;
                break;
            end
            @(posedge axi_aclk);
            #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_drain_timeout: got %0d beats pending want 0", nm, q.size());
        end
        chk({nm, "_pkt_cnt"}, pkt_cnt, want_cnt);
    endtask

    initial begin
        forever begin
            @(posedge axi_aclk);
            #1;
            if (tr_mode == 1) tready = ~tready;
            else tready = 1'b1;
        end
    end

    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge axi_aclk);
            chk("pkt_done", pkt_done, exp_done);
            chk("pkt_cnt", pkt_cnt, exp_cnt);
            if (exp_done) begin
                chk("idle_tvalid", tvalid, 1'b0);
                chk("idle_cmd_ready", cmd_ready, 1'b1);
            end
            exp_done = 0;
            if (tvalid) begin
                if (gap >= 0) begin
                    if (chk_gap) chk("idle_gap", gap, 1);
                    gap = -1;
                end
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got tvalid=1 want no beat");
                end else begin
                    e = q[0];
                    chk("tdata", tdata, e.d);
                    chk("tparity", tparity, m_par(e.d));
                    chk("tkeep", tkeep, e.k);
                    chk("tlast", tlast, e.l);
                    chk("tusr", tusr, e.u);
                    if (tready) begin
                        void'(q.pop_front());
                        pops++;
                        if (e.l) begin
                            exp_cnt  = exp_cnt + 1;
                            exp_done = 1;
                            gap      = 0;
                        end
                    end
                end
            end else if (gap >= 0) begin
                gap++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bit ok;
        axi_aresetn = 1'b0;
        cmd_valid   = 1'b0;
        cmd_qid     = '0;
        cmd_len     = '0;
        cmd_seed    = '0;
        tready      = 1'b1;
        #3;
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_tlast", tlast, 1'b0);
        chk("rst_tdata", tdata, '0);
        chk("rst_tparity", tparity, '0);
        chk("rst_tkeep", tkeep, '0);
        chk("rst_tusr", tusr, '0);
        chk("rst_pkt_cnt", pkt_cnt, '0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_err_len0", err_len0, 1'b0);
        #9;
        axi_aresetn = 1'b1;
        #1;
        chk("rel_cmd_ready_before_edge", cmd_ready, 1'b0);
        @(posedge axi_aclk);
        #1;
        chk("rel_cmd_ready_after_edge", cmd_ready, 1'b1);

        // single full beat
        issue(5, 64, 16'h0000);
        drain(1, "one_beat");
        // two beats, tail of one byte, word wrap
        issue(7, 65, 16'hFFF0);
        drain(2, "len65");
        // four beats with tready toggling
        tr_mode = 1;
        issue(11'h7FF, 200, 16'h1234);
        drain(3, "len200_stall");
        tr_mode = 0;
        @(posedge axi_aclk);
        #1;

        // zero-length command
        issue(3, 0, 16'h0042);
        @(negedge axi_aclk);
        chk("len0_err_pulse", err_len0, 1'b1);
        chk("len0_tvalid", tvalid, 1'b0);
        chk("len0_cmd_ready", cmd_ready, 1'b1);
        @(negedge axi_aclk);
        chk("len0_err_clear", err_len0, 1'b0);
        chk("len0_pkt_cnt", pkt_cnt, 32'd3);
        @(posedge axi_aclk);
        #1;

        // back-to-back commands
        gap = -1;
        chk_gap = 1;
        issue(1, 128, 16'h0100);
        issue(2, 1, 16'h7FFF);
        issue(4, 100, 16'hFFFF);
        drain(6, "b2b");
        chk_gap = 0;

        // maximum packet
        issue(9, 65535, 16'hABCD);
        drain(7, "max_len");

        // reset while beat 2 of a 10-beat packet is presented
        issue(3, 640, 16'h0100);
        p0 = pops;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge axi_aclk);
            #2;
            if (pops - p0 == 2) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL midpkt_wait: got %0d beats want 2", pops - p0);
        end
        chk("midpkt_tvalid_before", tvalid, 1'b1);
        axi_aresetn = 1'b0;
        q.delete();
        exp_cnt  = 0;
        exp_done = 0;
        gap      = -1;
        #1;
        chk("midpkt_rst_tvalid", tvalid, 1'b0);
        chk("midpkt_rst_tlast", tlast, 1'b0);
        chk("midpkt_rst_pkt_cnt", pkt_cnt, '0);
        chk("midpkt_rst_cmd_ready", cmd_ready, 1'b0);
        @(posedge axi_aclk);
        @(posedge axi_aclk);
        #2;
        axi_aresetn = 1'b1;
        @(posedge axi_aclk);
        #1;
        chk("midpkt_rel_cmd_ready", cmd_ready, 1'b1);
        issue(9, 128, 16'h5555);
        drain(1, "after_reset");

        repeat (3) @(posedge axi_aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_pcie_c2h_axis_gen.md
DMA_PCIE_C2H_AXIS_GEN -- requirements
Module: dma_pcie_c2h_axis_gen

Interface
REQ-001 SHALL have parameter TUSER_W, default 32, meaning the C2H sideband width; the only legal value is 32.
REQ-002 SHALL have parameter LEN_W, default 16, meaning the packet byte-length width; the only legal value is 16.
REQ-003 SHALL use one clock, axi_aclk; reset axi_aresetn is asynchronous and active-low.
REQ-004 Ports (name, direction, width, meaning):
- axi_aclk, input, 1: clock.
- axi_aresetn, input, 1: async active-low reset.
- cmd_valid, input, 1: packet command valid.
- cmd_ready, output, 1: command accept.
- cmd_qid, input, 11: destination queue.
- cmd_len, input, LEN_W: packet length in bytes.
- cmd_seed, input, 16: data pattern seed.
- tdata, output, 512: C2H stream data.
- tparity, output, 64: per-byte parity.
- tkeep, output, 64: byte enables.
- tlast, output, 1: last beat of packet.
- tvalid, output, 1: beat valid.
- tready, input, 1: sink ready.
- tusr, output, TUSER_W: C2H sideband.
- pkt_done, output, 1: one-cycle pulse on last-beat handshake.
- err_len0, output, 1: one-cycle pulse on zero-length command.
- pkt_cnt, output, 32: completed-packet counter.

Function
REQ-005 SHALL implement FSM states IDLE and SEND; cmd_ready = 1 only in IDLE (registered state, no combinational path from cmd_valid).
REQ-006 In IDLE, on cmd_valid && cmd_len != 0: latch qid/len/seed, set beats = ceil(len/64), beat index b = 0, enter SEND; tvalid = 1 on the next cycle.
REQ-007 In IDLE, on cmd_valid && cmd_len == 0: consume the command, pulse err_len0 for one cycle the next cycle, emit no beat, stay in IDLE.
REQ-008 Beat b data: 16-bit word k (k = 0..31, tdata[16k+15:16k]) = (seed + 32*b + k) mod 2^16.
REQ-009 tparity[i] = XOR of tdata[8i+7:8i] for i = 0..63, valid whenever tvalid = 1.
REQ-010 tkeep = all ones on non-last beats. On the last beat, tkeep has bits [r-1:0] set where r = len mod 64, or all ones if r = 0.
REQ-011 tlast = 1 only on beat b = beats-1.
REQ-012 tusr = {5'b0, len[15:0], qid[10:0]}, constant for all beats of a packet.
REQ-013 While tvalid && !tready, tdata, tparity, tkeep, tlast and tusr SHALL hold stable and tvalid SHALL stay 1.
REQ-014 Handshake = tvalid && tready. A non-last handshake advances b, and the next beat presents the next cycle; with tready held high, throughput is one beat per cycle.
REQ-015 Last-beat handshake: tvalid deasserts the next cycle; pkt_done pulses 1 cycle (registered, same edge tvalid falls); pkt_cnt increments with wrap at 2^32; FSM returns to IDLE.
REQ-016 Exactly one idle cycle (cmd_ready high, tvalid low) SHALL separate consecutive packets.
REQ-017 Beat counter width SHALL be 10 bits; the maximum packet of 65535 bytes is 1024 beats, with a last beat of r = 63.
REQ-018 Inputs cmd_* are ignored outside IDLE; tready while tvalid = 0 has no effect.

Reset
REQ-019 On axi_aresetn = 0, asynchronously: FSM = IDLE, tvalid = 0, tlast = 0, tdata = 0, tparity = 0, tkeep = 0, tusr = 0, pkt_done = 0, err_len0 = 0, pkt_cnt = 0, beat counter = 0.
REQ-020 cmd_ready = 0 while reset is asserted and 1 from the first clock edge after deassertion.
REQ-021 Reset mid-packet SHALL abort the packet with no tlast, and SHALL NOT increment pkt_cnt; the next command after reset starts at b = 0.

Verification
REQ-022 qid = 5, len = 64, seed = 0x0000, tready = 1 -> one beat: tkeep = all ones, tlast = 1, word0 = 0x0000, word31 = 0x001F, tusr = 0x00020005, pkt_done pulse, pkt_cnt = 1.
REQ-023 len = 65, seed = 0xFFF0 -> two beats: beat1 tkeep = 0x...0001, tlast only on beat1, beat1 word0 = 0x0010 (wrap).
REQ-024 len = 200, tready toggling 1/0 every cycle -> 4 beats, all outputs stable during stalls, last tkeep = 0x00FF, no beat lost or duplicated.
REQ-025 cmd_len = 0 -> err_len0 single pulse, tvalid stays 0, pkt_cnt unchanged, cmd_ready high again the next cycle.
REQ-026 Reset asserted during beat 2 of a 10-beat packet -> tvalid = 0 immediately, pkt_cnt = 0; a new len = 128 command then yields 2 beats starting at word0 = seed.
REQ-027 Every beat in all scenarios -> tparity matches byte XOR per REQ-009; back-to-back commands show exactly one idle cycle between packets.
